// File: rtl/fifo_s1_sf.sv
// Single-clock synchronous FIFO with active-low push/pop requests and occupancy flags.
// Flags come from the registered count only, so no request input reaches an output.
module fifo_s1_sf #(
    parameter int unsigned width    = 8,
    parameter int unsigned depth    = 4,
    parameter int unsigned ae_level = 1,
    parameter int unsigned af_level = 1,
    parameter int unsigned err_mode = 0,
    parameter int unsigned rst_mode = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_req_n,
    input  logic             pop_req_n,
    input  logic             diag_n,
    input  logic [width-1:0] data_in,
    output logic             empty,
    output logic             almost_empty,
    output logic             half_full,
    output logic             almost_full,
    output logic             full,
    output logic             error,
    output logic [width-1:0] data_out
);

    localparam int unsigned PtrW = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned CntW = $clog2(depth + 1);

    logic [PtrW-1:0]  wrPtr, wrPtrNext;
    logic [PtrW-1:0]  rdPtr, rdPtrNext;
    logic [CntW-1:0]  count, countNext;
    logic             errQ, errNext;
    logic [width-1:0] mem [depth];

    logic pushAcc, popAcc, overflow, underflow;
    logic unusedDiag;

    assign unusedDiag = diag_n;

    assign empty        = (count == '0);
    assign full         = (count == CntW'(depth));
    assign almost_empty = (count <= CntW'(ae_level));
    assign half_full    = (count >= CntW'(depth / 2));
    assign almost_full  = (count >= CntW'(depth - af_level));
    assign error        = errQ;
    assign data_out     = mem[rdPtr];

    // A push while full still goes through when a pop frees the head slot this cycle.
    assign popAcc    = !pop_req_n && !empty;
    assign pushAcc   = !push_req_n && (!full || popAcc);
    assign overflow  = !push_req_n && full && !popAcc;
    assign underflow = !pop_req_n && empty;

    always_comb begin
        wrPtrNext = wrPtr;
        rdPtrNext = rdPtr;
        countNext = count;
        if (pushAcc) begin
            wrPtrNext = (wrPtr == PtrW'(depth - 1)) ? '0 : wrPtr + 1'b1;
        end
        if (popAcc) begin
            rdPtrNext = (rdPtr == PtrW'(depth - 1)) ? '0 : rdPtr + 1'b1;
        end
        unique case ({pushAcc, popAcc})
            2'b10:   countNext = count + 1'b1;
            2'b01:   countNext = count - 1'b1;
            default: countNext = count;
        endcase
        if (err_mode < 2) begin
            errNext = errQ | overflow | underflow;
        end else begin
            errNext = overflow | underflow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            errQ  <= 1'b0;
        end else begin
            wrPtr <= wrPtrNext;
            rdPtr <= rdPtrNext;
            count <= countNext;
            errQ  <= errNext;
        end
    end

    generate
        if (rst_mode < 2) begin : gen_mem_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(depth); i++) begin
                        mem[i] <= '0;
                    end
                end else if (pushAcc) begin
                    mem[wrPtr] <= data_in;
                end
            end
        end else begin : gen_mem_norst
            always_ff @(posedge clk) begin
                if (pushAcc) begin
                    mem[wrPtr] <= data_in;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_s1_sf.sv
// Directed bench for fifo_s1_sf: two depth-4/width-32 instances on shared stimulus,
// one with pulsed error (err_mode 2) and one with sticky error (err_mode 0).
module tb_fifo_s1_sf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        push_req_n = 1'b1;
    logic        pop_req_n = 1'b1;
    logic        diag_n = 1'b1;
    logic [31:0] data_in = '0;

    logic        emptyA, aeA, hfA, afA, fullA, errA;
    logic        emptyB, aeB, hfB, afB, fullB, errB;
    logic [31:0] doutA, doutB;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fifo_s1_sf #(.width(32), .depth(4), .ae_level(1), .af_level(1), .err_mode(2), .rst_mode(0))
        dutA (
            .clk(clk), .rst_n(rst_n), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
            .diag_n(diag_n), .data_in(data_in), .empty(emptyA), .almost_empty(aeA),
            .half_full(hfA), .almost_full(afA), .full(fullA), .error(errA), .data_out(doutA)
        );

    fifo_s1_sf #(.width(32), .depth(4), .ae_level(1), .af_level(1), .err_mode(0), .rst_mode(0))
        dutB (
            .clk(clk), .rst_n(rst_n), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
            .diag_n(diag_n), .data_in(data_in), .empty(emptyB), .almost_empty(aeB),
            .half_full(hfB), .almost_full(afB), .full(fullB), .error(errB), .data_out(doutB)
        );

    // Flag vectors packed as {empty, almost_empty, half_full, almost_full, full}.
    function automatic logic [4:0] flagsA();
        return {emptyA, aeA, hfA, afA, fullA};
    endfunction

    function automatic logic [4:0] flagsB();
        return {emptyB, aeB, hfB, afB, fullB};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (flagsA() !== 5'b11000) begin
            bad++; $display("FAIL reset_flagsA got=%b want=%b", flagsA(), 5'b11000);
        end
        total++;
        if (flagsB() !== 5'b11000) begin
            bad++; $display("FAIL reset_flagsB got=%b want=%b", flagsB(), 5'b11000);
        end
        total++;
        if ({errA, errB} !== 2'b00) begin
            bad++; $display("FAIL reset_error got=%b want=00", {errA, errB});
        end
        total++;
        if (doutA !== 32'h0) begin
            bad++; $display("FAIL reset_dout got=%h want=%h", doutA, 32'h0);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [31:0] vals [4];
        logic [4:0]  expF [4];
        vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        expF = '{5'b01000, 5'b00100, 5'b00110, 5'b00111};
        for (int i = 0; i < 4; i++) begin
            push_req_n = 1'b0;
            data_in = vals[i];
            tick();
            total++;
            if (flagsA() !== expF[i]) begin
                bad++; $display("FAIL fill_flags[%0d] got=%b want=%b", i, flagsA(), expF[i]);
            end
            total++;
            if (doutA !== 32'h11) begin
                bad++; $display("FAIL fill_dout[%0d] got=%h want=%h", i, doutA, 32'h11);
            end
        end
        push_req_n = 1'b1;
    endtask

    task automatic test_overflow();
        push_req_n = 1'b0;
        data_in = 32'h55;
        tick();
        push_req_n = 1'b1;
        total++;
        if ({errA, errB} !== 2'b11) begin
            bad++; $display("FAIL ovf_error_rise got=%b want=11", {errA, errB});
        end
        total++;
        if (flagsA() !== 5'b00111) begin
            bad++; $display("FAIL ovf_still_full got=%b want=%b", flagsA(), 5'b00111);
        end
        tick();
        total++;
        if ({errA, errB} !== 2'b01) begin
            bad++; $display("FAIL ovf_error_fall got=%b want=01", {errA, errB});
        end
    endtask

    task automatic test_drain();
        logic [31:0] vals [4];
        logic [4:0]  expF [4];
        vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        expF = '{5'b00110, 5'b00100, 5'b01000, 5'b11000};
        for (int i = 0; i < 4; i++) begin
            pop_req_n = 1'b0;
            #1;
            total++;
            if (doutA !== vals[i]) begin
                bad++; $display("FAIL drain_dout[%0d] got=%h want=%h", i, doutA, vals[i]);
            end
            tick();
            total++;
            if (flagsA() !== expF[i]) begin
                bad++; $display("FAIL drain_flags[%0d] got=%b want=%b", i, flagsA(), expF[i]);
            end
        end
        pop_req_n = 1'b1;
        total++;
        if (errA !== 1'b0) begin
            bad++; $display("FAIL drain_errA got=%b want=0", errA);
        end
    endtask

    task automatic test_underflow();
        pulse_reset();
        total++;
        if (errB !== 1'b0) begin
            bad++; $display("FAIL unf_pre_errB got=%b want=0", errB);
        end
        pop_req_n = 1'b0;
        tick();
        pop_req_n = 1'b1;
        total++;
        if ({errA, errB, emptyA} !== 3'b111) begin
            bad++; $display("FAIL unf_rise got=%b want=111", {errA, errB, emptyA});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({errA, errB} !== 2'b01) begin
                bad++; $display("FAIL unf_hold[%0d] got=%b want=01", i, {errA, errB});
            end
        end
        // Pop on empty with a push: the push must still land.
        pop_req_n = 1'b0;
        push_req_n = 1'b0;
        data_in = 32'h77;
        tick();
        pop_req_n = 1'b1;
        push_req_n = 1'b1;
        total++;
        if ({emptyA, errA} !== 2'b01 || doutA !== 32'h77) begin
            bad++; $display("FAIL unf_push got=%b/%h want=01/%h", {emptyA, errA}, doutA, 32'h77);
        end
        pulse_reset();
        total++;
        if ({errB, emptyB} !== 2'b01) begin
            bad++; $display("FAIL unf_cleared got=%b want=01", {errB, emptyB});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] model [$];
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            push_req_n = 1'b0;
            data_in = 32'h11 * (i + 1);
            tick();
        end
        model = '{32'h22, 32'h33, 32'h44, 32'h66};
        push_req_n = 1'b0;
        pop_req_n = 1'b0;
        data_in = 32'h66;
        tick();
        total++;
        if (fullA !== 1'b1 || {errA, errB} !== 2'b00 || doutA !== 32'h22) begin
            bad++; $display("FAIL simul_full got=%b%b%b/%h want=100/%h",
                            fullA, errA, errB, doutA, 32'h22);
        end
        for (int i = 0; i < 10; i++) begin
            w = 32'h80 + 32'(i);
            data_in = w;
            #1;
            total++;
            if (doutB !== model[0]) begin
                bad++; $display("FAIL wrap_dout[%0d] got=%h want=%h", i, doutB, model[0]);
            end
            tick();
            void'(model.pop_front());
            model.push_back(w);
        end
        push_req_n = 1'b1;
        pop_req_n = 1'b1;
        total++;
        if (flagsB() !== 5'b00111 || errB !== 1'b0 || doutB !== model[0]) begin
            bad++; $display("FAIL wrap_end got=%b%b/%h want=001110/%h",
                            flagsB(), errB, doutB, model[0]);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_s1_sf.md
# fifo_s1_sf

Single-clock, single-port-each-side synchronous FIFO with active-low push/pop requests, registered occupancy flags and an error flag. Vector-lane read pipes use it to buffer VRF read results after a fixed read latency: one instance per requester, parameterised depth 4, width 32. It stores nothing beyond `depth` words. It gives no back-pressure other than the `full` flag, which the producer must honour.

## Interface

Parameters:
- `width`, default 8: data word width in bits, range 1–256.
- `depth`, default 4: number of storage words, range 2–256.
- `ae_level`, default 1: almost-empty threshold in words, range 1..depth-1.
- `af_level`, default 1: almost-full threshold in words, range 1..depth-1.
- `err_mode`, default 0: error-flag behaviour.
  - 0 or 1: sticky until reset.
  - 2: non-sticky, asserted only for the cycle after the offending request.
- `rst_mode`, default 0: memory reset behaviour.
  - 0 or 1: storage array cleared by reset.
  - 2 or 3: storage not cleared.
  - Reset is asynchronous in all modes.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `push_req_n`, input, 1: push request, active-low.
- `pop_req_n`, input, 1: pop request, active-low.
- `diag_n`, input, 1: reserved; tie high. It has no effect in any mode.
- `data_in`, input, `width`: word written on an accepted push.
- `empty`, output, 1: high when count == 0.
- `almost_empty`, output, 1: high when count <= `ae_level`.
- `half_full`, output, 1: high when count >= depth/2 (integer division).
- `almost_full`, output, 1: high when count >= depth − `af_level`.
- `full`, output, 1: high when count == depth.
- `error`, output, 1: overflow/underflow indicator, registered.
- `data_out`, output, `width`: word at the read pointer, i.e. the FIFO head.

## Operation

- State:
  - write pointer `wp` and read pointer `rp`, each ceil(log2 depth) bits, wrapping from depth−1 to 0 (non-power-of-2 depth supported);
  - occupancy count, 0..depth;
  - storage array of `depth` × `width`;
  - error register.
- Accepted push: `push_req_n`=0 and not `full`, or `push_req_n`=0 with `full` and an accepted pop in the same cycle.
  - Writes `data_in` to mem[wp] and increments `wp`.
- Accepted pop: `pop_req_n`=0 and not `empty`.
  - Increments `rp`.
  - The popped word is the `data_out` value presented during that cycle.
- Count update:
  - +1 on push only;
  - −1 on pop only;
  - unchanged on both or neither.
- Overflow: push while `full` with no accepted pop.
  - The push is dropped and storage/pointers are untouched.
  - The error condition is raised.
- Underflow: pop while `empty`.
  - The pop is ignored.
  - A simultaneous push is still accepted.
  - The error condition is raised.
- `err_mode` 0/1: `error` is set on the edge following the condition and held until reset.
- `err_mode` 2: `error` equals the registered value of (overflow | underflow) for the previous cycle only.
- `data_out` = mem[rp], driven combinationally from registered state; contents are don't-care while `empty`.
- All flags derive from the registered count, so there is no combinational path from the request inputs to any output.

## Timing

- Reset (`rst_n` low, asynchronous, no clock needed) gives:
  - `wp`=`rp`=count=0;
  - `error`=0;
  - `empty`=1, `almost_empty`=1;
  - `half_full`=0, `almost_full`=0, `full`=0.
- Storage under reset:
  - `rst_mode` 0/1: storage is cleared and `data_out`=0.
  - `rst_mode` 2/3: `data_out` is undefined until first written.
- Reset mid-operation discards all contents immediately.
- Write-to-read latency is 1 cycle: a word pushed at edge N appears on `data_out` and deasserts `empty` after edge N.
- Flags update one edge after the push/pop that changes count.
- `error` rises one edge after the offending request.
- Throughput: one push and one pop per cycle, sustained at any occupancy including full (with simultaneous pop) and empty (push only).
- Pointer wrap: after `depth` pushes, `wp` returns to 0 with no bubble.

## Test plan

- **Reset values.** Assert `rst_n`=0 mid-cycle with no clock edge → `empty`=1, `almost_empty`=1, `full`=0, `error`=0 immediately (depth=4, width=32).
- **Fill to full.** Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - After push 1: `empty`=0 and `almost_empty`=1.
  - After push 2: `half_full`=1.
  - After push 3: `almost_full`=1.
  - After push 4: `full`=1.
  - `data_out`=0x11 throughout.
- **Drain in order.** Pop 4 times from full → `data_out` sequence 0x11, 0x22, 0x33, 0x44, then `empty`=1, with the flags retracing in reverse.
- **Overflow, `err_mode`=2.** Push 0x55 while full with no pop → `error`=1 for exactly one cycle, count stays 4, subsequent pops still return 0x11..0x44.
- **Underflow, `err_mode`=0.** Pop while empty → `error`=1 and stays 1 until `rst_n` pulses low.
- **Simultaneous push/pop and wrap.**
  - Full, push 0x66 with pop → count stays 4, no error, `data_out` advances to 0x22.
  - Continuous push+pop for 10 cycles → words emerge in order across pointer wrap.
